// File: rtl/cpu_pkg.sv
// Shared CPU widths and the writeback request record carried through the
// long-latency result buffer.
package cpu_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
  } wb_req_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback bundle: pipe result, long-latency handshake, issue tracking,
// decode hazard query and the regfile write port.
interface regfile_writeback_if;
  import cpu_pkg::*;

  logic              pipe_valid;
  logic [REG_AW-1:0] pipe_wa;
  logic [XLEN-1:0]   pipe_wd;
  logic              pipe_stall;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_wa;
  logic [XLEN-1:0]   lsu_wd;
  logic              iss_valid;
  logic [REG_AW-1:0] iss_wa;
  logic [REG_AW-1:0] ra1;
  logic [REG_AW-1:0] ra2;
  logic              busy1;
  logic              busy2;
  logic              we;
  logic [REG_AW-1:0] wa;
  logic [XLEN-1:0]   wd;

  modport master (
    output pipe_valid, pipe_wa, pipe_wd, lsu_valid, lsu_wa, lsu_wd,
           iss_valid, iss_wa, ra1, ra2,
    input  pipe_stall, lsu_ready, busy1, busy2, we, wa, wd
  );

  modport slave (
    input  pipe_valid, pipe_wa, pipe_wd, lsu_valid, lsu_wa, lsu_wd,
           iss_valid, iss_wa, ra1, ra2,
    output pipe_stall, lsu_ready, busy1, busy2, we, wa, wd
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. Pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate count.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_req_t     mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/regfile_writeback.sv
// Single regfile write port arbiter: in-order pipe results win by default,
// buffered long-latency results are forced through after STARVE_LIMIT losses.
module regfile_writeback
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  regfile_writeback_if.slave bus
);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            starve;
  logic            commit_pipe;
  wb_req_t         head;
  wb_req_t         lsu_req;
  logic [SCW-1:0]  starve_cnt;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  assign lsu_req = '{wa: bus.lsu_wa, wd: bus.lsu_wd};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (lsu_req),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.lsu_ready  = !rst && !full;
  assign push           = bus.lsu_valid && bus.lsu_ready;
  assign starve         = !empty && (starve_cnt == SCW'(STARVE_LIMIT));
  assign pop            = !empty && (starve || !bus.pipe_valid);
  assign commit_pipe    = bus.pipe_valid && !starve;
  assign bus.pipe_stall = bus.pipe_valid && starve;
  assign bus.busy1      = pending[bus.ra1];
  assign bus.busy2      = pending[bus.ra2];

  // Issue is applied after the pop clear so a same-register set survives.
  always_comb begin
    pending_nxt = pending;
    if (pop)           pending_nxt[head.wa]    = 1'b0;
    if (bus.iss_valid) pending_nxt[bus.iss_wa] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      pending    <= '0;
      bus.we     <= 1'b0;
      bus.wa     <= '0;
      bus.wd     <= '0;
    end else begin
      assert (!(bus.iss_valid && (bus.iss_wa != '0) && pending[bus.iss_wa] &&
                !(pop && (head.wa == bus.iss_wa))));
      pending <= pending_nxt;
      if (empty || pop)     starve_cnt <= '0;
      else if (commit_pipe) starve_cnt <= starve_cnt + 1'b1;
      if (pop) begin
        bus.we <= (head.wa != '0);
        bus.wa <= head.wa;
        bus.wd <= head.wd;
      end else if (commit_pipe) begin
        bus.we <= (bus.pipe_wa != '0);
        bus.wa <= bus.pipe_wa;
        bus.wd <= bus.pipe_wd;
      end else begin
        bus.we <= 1'b0;
      end
    end
  end
endmodule
